// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared slice-width helper, stage-range limits and add/sub opcode encoding
package pipelined_addsub_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    function automatic int slice_w(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit stages_ok(input int n, input int stages);
        return stages >= STAGES_MIN && stages <= STAGES_MAX && n % stages == 0;
    endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// addsub_slice: W-bit combinational slice adder with carry-out and carry-into-MSB
module addsub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign cmsb      = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep sliced add/subtract with valid/ready backpressure; optional saturation via PIPELINED_ADDSUB_SAT_EN
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_sub,
    input  logic         in_cin,
`ifdef PIPELINED_ADDSUB_SAT_EN
    input  logic         in_sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_s,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int W = slice_w(N, STAGES);
    localparam logic [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

    if (!stages_ok(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: STAGES must be 1..8 and divide N");
    end

    logic         adv;
    logic [N-1:0] a_i   [STAGES];
    logic [N-1:0] b_i   [STAGES];
    logic [N-1:0] s_i   [STAGES];
    logic         c_i   [STAGES];
    logic         v_i   [STAGES];
    logic         sat_i [STAGES];

    // the whole pipe moves together whenever the output slot is free or being taken
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // subtract is A + ~B + 1; add uses the caller's carry-in
    assign a_i[0] = in_a;
    assign b_i[0] = op_e'(in_sub) == OP_SUB ? ~in_b : in_b;
    assign c_i[0] = op_e'(in_sub) == OP_SUB ? 1'b1 : in_cin;
    assign s_i[0] = '0;
    assign v_i[0] = in_valid;
`ifdef PIPELINED_ADDSUB_SAT_EN
    assign sat_i[0] = in_sat;
`else
    assign sat_i[0] = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [W-1:0] sl_s;
        logic         sl_c;
        logic         sl_m;
        logic [N-1:0] s_n;

        addsub_slice #(.W(W)) u_slice (
            .a    (a_i[k][k*W +: W]),
            .b    (b_i[k][k*W +: W]),
            .cin  (c_i[k]),
            .s    (sl_s),
            .cout (sl_c),
            .cmsb (sl_m)
        );

        // merge this stage's slice into the partial sum carried down the pipe
        always_comb begin
            s_n = s_i[k];
            s_n[k*W +: W] = sl_s;
        end

        if (k < STAGES - 1) begin : g_mid
            logic         v_q;
            logic         c_q;
            logic         sat_q;
            logic [N-1:0] a_q;
            logic [N-1:0] b_q;
            logic [N-1:0] s_q;

            // stage valid bit; bubbles load as valid=0
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) v_q <= 1'b0;
                else if (adv) v_q <= v_i[k];
            end

            // payload carries operands, partial sum and slice carry; no reset needed
            always_ff @(posedge aclk) begin
                if (adv) begin
                    a_q   <= a_i[k];
                    b_q   <= b_i[k];
                    s_q   <= s_n;
                    c_q   <= sl_c;
                    sat_q <= sat_i[k];
                end
            end

            assign v_i[k+1]   = v_q;
            assign a_i[k+1]   = a_q;
            assign b_i[k+1]   = b_q;
            assign s_i[k+1]   = s_q;
            assign c_i[k+1]   = c_q;
            assign sat_i[k+1] = sat_q;
        end else begin : g_last
            logic         ovf_n;
            logic [N-1:0] r_n;

            assign ovf_n = sl_m ^ sl_c;
            assign r_n   = sat_i[k] && ovf_n ? (a_i[k][N-1] ? S_MIN : S_MAX) : s_n;

            // output register: result, flags and valid, all held while stalled
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    out_valid <= 1'b0;
                    out_s     <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_i[k];
                    out_s     <= r_n;
                    out_cout  <= sl_c;
                    out_ovf   <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed checks of arithmetic, latency, backpressure and async reset
module tb_pipelined_addsub;

    localparam int N      = 32;
    localparam int STAGES = 2;

    logic          aclk      = 1'b0;
    logic          aresetn   = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_sub    = 1'b0;
    logic          in_cin    = 1'b0;
    logic          out_ready = 1'b1;
    logic [N-1:0]  in_a      = '0;
    logic [N-1:0]  in_b      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_cout;
    logic          out_ovf;
    logic [N-1:0]  out_s;
`ifdef PIPELINED_ADDSUB_SAT_EN
    logic          in_sat    = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    pipelined_addsub #(.N(N), .STAGES(STAGES)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
`ifdef PIPELINED_ADDSUB_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        #1 aresetn = 1'b0;
        @(negedge aclk);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_s !== '0) begin errors++; $display("FAIL reset_s: got %h want 0", out_s); end
        vectors++;
        if ({out_cout, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {out_cout, out_ovf}); end
        aresetn = 1'b1;
        @(negedge aclk);
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_arith;
        vec_t tv [8] = '{
            '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
            '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1},
            '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0},
            '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            in_a = tv[i].a; in_b = tv[i].b; in_sub = tv[i].sub; in_cin = tv[i].cin; in_valid = 1'b1;
            @(negedge aclk);
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL arith%0d_early_valid: got %b want 0", i, out_valid); end
            @(negedge aclk);
            vectors++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_valid: got %b want 1", i, out_valid); end
            vectors++;
            if (out_s !== tv[i].s) begin errors++; $display("FAIL arith%0d_s: got %h want %h", i, out_s, tv[i].s); end
            vectors++;
            if ({out_cout, out_ovf} !== {tv[i].c, tv[i].o}) begin
                errors++;
                $display("FAIL arith%0d_flags: got cout=%b ovf=%b want cout=%b ovf=%b", i, out_cout, out_ovf, tv[i].c, tv[i].o);
            end
        end
        @(negedge aclk);
    endtask

    task automatic test_back_to_back;
        logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [N-1:0]  exp_s [8];
        logic [N-1:0]  prev_s = '0;
        logic          prev_stall = 1'b0;
        int            sent = 0;
        int            recv = 0;
        for (int i = 0; i < 8; i++) exp_s[i] = (32'h0000_FFFF + i * 32'h1000_0000) + (i + 1);
        in_sub = 1'b0; in_cin = 1'b0;
        for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
            @(negedge aclk);
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_s !== prev_s) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b s=%h want valid=1 s=%h", out_valid, out_s, prev_s);
                end
            end
            out_ready = pat[cyc % 4];
            in_valid  = sent < 8;
            in_a      = 32'h0000_FFFF + sent * 32'h1000_0000;
            in_b      = sent + 1;
            #1;
            vectors++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL stream_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (out_s !== exp_s[recv]) begin errors++; $display("FAIL stream_beat%0d: got %h want %h", recv, out_s, exp_s[recv]); end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = out_s;
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        vectors++;
        if (recv !== 8) begin errors++; $display("FAIL stream_count: got %0d want 8", recv); end
        out_ready = 1'b1;
        repeat (3) @(negedge aclk);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_dup: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_midreset;
        out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
        @(negedge aclk);
        in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
        @(negedge aclk);
        in_a = 32'd3; in_b = 32'd4;
        @(negedge aclk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got %b want 1", out_valid); end
        #2 aresetn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_s !== '0) begin errors++; $display("FAIL midrst_async_s: got %h want 0", out_s); end
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: got %b want 0", i, out_valid); end
        end
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    endtask

`ifdef PIPELINED_ADDSUB_SAT_EN
    task automatic test_sat;
        logic [31:0] a_v [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] b_v [3] = '{32'h0000_0010, 32'h0000_0010, 32'hFFFF_FFF0};
        logic        t_v [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] s_v [3] = '{32'h7FFF_FFFF, 32'h8000_000F, 32'h8000_0000};
        out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            in_a = a_v[i]; in_b = b_v[i]; in_sat = t_v[i]; in_valid = 1'b1;
            @(negedge aclk);
            in_valid = 1'b0;
            @(negedge aclk);
            vectors++;
            if (out_valid !== 1'b1 || out_s !== s_v[i]) begin
                errors++;
                $display("FAIL sat%0d_s: got valid=%b s=%h want valid=1 s=%h", i, out_valid, out_s, s_v[i]);
            end
            vectors++;
            if (out_ovf !== 1'b1) begin errors++; $display("FAIL sat%0d_ovf: got %b want 1", i, out_ovf); end
        end
        in_sat = 1'b0;
        @(negedge aclk);
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_midreset();
`ifdef PIPELINED_ADDSUB_SAT_EN
        test_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
